branch_unit: RTL and testbench

Program-counter and branch-resolution block for the datapath CPU. Latches the ALU status flags (Z, N, V) into the status register and owns the PC register. Accepts one branch request at a time from the controller FSM over a valid/ready handshake, evaluates the condition against the latched flags, and commits the next PC, with an optional link write-back.

---
 rtl/cpu_branch_pkg.sv | 24 ++
 rtl/branch_unit_if.sv | 27 ++
 rtl/cond_eval.sv | 31 +++
 rtl/branch_unit.sv | 147 ++++++++++++++
 tb/tb_branch_unit.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_branch_pkg.sv
// cpu_branch_pkg: shared encodings for the branch unit.
// Holds br_op/br_cond codes, status flag bit indices and FSM state codes.
package cpu_branch_pkg;

    localparam logic [2:0] OP_COND = 3'b000;
    localparam logic [2:0] OP_BL   = 3'b001;
    localparam logic [2:0] OP_BX   = 3'b010;
    localparam logic [2:0] OP_BLX  = 3'b011;

    localparam logic [2:0] CC_AL = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_NE = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_LE = 3'b100;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/branch_unit_if.sv
// branch_unit_if: branch request handshake and commit result bundle.
// master = controller (drives request), slave = branch_unit (drives ready/result).
interface branch_unit_if #(
    parameter int IMM_W = 8
);
    logic             br_valid;
    logic             br_ready;
    logic [2:0]       br_op;
    logic [2:0]       br_cond;
    logic [IMM_W-1:0] br_imm;
    logic [15:0]      rd_val;
    logic             res_valid;
    logic             taken;
    logic             link_we;
    logic [15:0]      link_out;

    modport master (
        output br_valid, br_op, br_cond, br_imm, rd_val,
        input  br_ready, res_valid, taken, link_we, link_out
    );

    modport slave (
        input  br_valid, br_op, br_cond, br_imm, rd_val,
        output br_ready, res_valid, taken, link_we, link_out
    );

endinterface

// File: rtl/cond_eval.sv
// cond_eval: combinational branch condition check against status flags.
// Ports: s[2:0] status (Z,N,V), cond[2:0] condition code, pass result.
module cond_eval
    import cpu_branch_pkg::*;
(
    input  logic [2:0] s,
    input  logic [2:0] cond,
    output logic       pass
);

    logic z;
    logic n;
    logic v;

    assign z = s[FLAG_Z];
    assign n = s[FLAG_N];
    assign v = s[FLAG_V];

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            CC_AL:   pass = 1'b1;
            CC_EQ:   pass = z;
            CC_NE:   pass = !z;
            CC_LT:   pass = (n != v);
            CC_LE:   pass = (n != v) || z;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// branch_unit: PC register, status register and 3-cycle branch resolver.
// Ports: clk, reset, flags_in/load_s/s_out, pc_inc/pc_out, br (branch_unit_if.slave);
// with BRANCH_STATS_EN defined also taken_cnt/nottaken_cnt saturating counters.
module branch_unit
    import cpu_branch_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int IMM_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      flags_in,
    input  logic            load_s,
    output logic [2:0]      s_out,
    input  logic            pc_inc,
    output logic [PC_W-1:0] pc_out,
`ifdef BRANCH_STATS_EN
    output logic [15:0]     taken_cnt,
    output logic [15:0]     nottaken_cnt,
`endif
    branch_unit_if.slave    br
);

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic [2:0]       cond_q;
    logic [IMM_W-1:0] imm_q;
    logic [PC_W-1:0]  rd_q;
    logic [PC_W-1:0]  pc_cap;

    logic             accept;
    logic             pass;
    logic             tk;
    logic             lwe;
    logic [PC_W-1:0]  tgt;
    logic [PC_W-1:0]  rel;
    logic             unused_rd;

    // Only the low PC_W bits of a register target are meaningful.
    assign unused_rd = ^br.rd_val[15:PC_W];

    assign br.br_ready = (state == IDLE);
    assign accept      = br.br_valid && (state == IDLE);

    cond_eval u_cond (
        .s    (s_out),
        .cond (cond_q),
        .pass (pass)
    );

    // Relative target; wraps modulo 2^PC_W in both directions.
    assign rel = pc_cap + {{(PC_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

    always_comb begin
        tk  = 1'b0;
        lwe = 1'b0;
        tgt = rel;
        unique case (op_q)
            OP_COND: tk = pass;
            OP_BL: begin
                tk  = 1'b1;
                lwe = 1'b1;
            end
            OP_BX: begin
                tk  = 1'b1;
                tgt = rd_q;
            end
            OP_BLX: begin
                tk  = 1'b1;
                lwe = 1'b1;
                tgt = rd_q;
            end
            default: begin
                tk  = 1'b0;
                lwe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s_out        <= 3'b000;
            pc_out       <= '0;
            op_q         <= '0;
            cond_q       <= '0;
            imm_q        <= '0;
            rd_q         <= '0;
            pc_cap       <= '0;
            br.res_valid <= 1'b0;
            br.taken     <= 1'b0;
            br.link_we   <= 1'b0;
            br.link_out  <= '0;
        end else begin
            if (load_s) begin
                s_out <= flags_in;
            end
            br.res_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= br.br_op;
                        cond_q <= br.br_cond;
                        imm_q  <= br.br_imm;
                        rd_q   <= br.rd_val[PC_W-1:0];
                        pc_cap <= pc_out;
                        state  <= EVAL;
                    end else if (pc_inc) begin
                        pc_out <= pc_out + PC_W'(1);
                    end
                end
                // Evaluation uses s_out as it stands in EVAL, so a load in
                // the accept cycle counts and a load during EVAL does not.
                EVAL: begin
                    state        <= DONE;
                    br.res_valid <= 1'b1;
                    br.taken     <= tk;
                    br.link_we   <= lwe;
                    br.link_out  <= {{(16-PC_W){1'b0}}, pc_cap};
                    if (tk) begin
                        pc_out <= tgt;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
        end else if (state == EVAL) begin
            if (tk) begin
                if (taken_cnt != 16'hFFFF) begin
                    taken_cnt <= taken_cnt + 16'd1;
                end
            end else if (nottaken_cnt != 16'hFFFF) begin
                nottaken_cnt <= nottaken_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: scoreboard bench for branch_unit.
// Directed plus randomized branches against a behavioural model.
module tb_branch_unit;
    import cpu_branch_pkg::*;

    localparam int PC_W  = 9;
    localparam int IMM_W = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      flags_in;
    logic            load_s;
    logic [2:0]      s_out;
    logic            pc_inc;
    logic [PC_W-1:0] pc_out;
`ifdef BRANCH_STATS_EN
    logic [15:0]     taken_cnt;
    logic [15:0]     nottaken_cnt;
`endif

    branch_unit_if #(.IMM_W(IMM_W)) bif ();

    branch_unit #(.PC_W(PC_W), .IMM_W(IMM_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .flags_in     (flags_in),
        .load_s       (load_s),
        .s_out        (s_out),
        .pc_inc       (pc_inc),
        .pc_out       (pc_out),
`ifdef BRANCH_STATS_EN
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt),
`endif
        .br           (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tk;
        logic [8:0]  pc;
        logic        lwe;
        logic [15:0] link;
        int          at;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [8:0] mpc;
    logic [2:0] ms;
    int         mtk;
    int         mnt;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bif.res_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_res_valid got 1 want 0 at cycle %0d",
                         cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("taken", {31'd0, bif.taken}, {31'd0, e.tk});
                check("pc_out", {23'd0, pc_out}, {23'd0, e.pc});
                check("link_we", {31'd0, bif.link_we}, {31'd0, e.lwe});
                check("link_out", {16'd0, bif.link_out}, {16'd0, e.link});
                check("latency", cyc, e.at);
            end
        end
    end

    // Reference: the architectural branch rules on plain integers.
    function automatic exp_t model(input logic [2:0] op, input logic [2:0] cond,
                                   input logic [7:0] imm, input logic [15:0] rd,
                                   input logic [2:0] s, input logic [8:0] pc);
        exp_t e;
        bit z, n, v, pass;
        int rel;
        z = s[0];
        n = s[1];
        v = s[2];
        case (cond)
            3'd0: pass = 1;
            3'd1: pass = z;
            3'd2: pass = !z;
            3'd3: pass = (n != v);
            3'd4: pass = (n != v) || z;
            default: pass = 0;
        endcase
        rel = (int'(pc) + int'($signed(imm))) & 511;
        e.link = {7'd0, pc};
        e.lwe = 0;
        e.tk = 0;
        e.pc = pc;
        e.at = 0;
        case (op)
            3'd0: begin e.tk = pass; if (pass) e.pc = 9'(rel); end
            3'd1: begin e.tk = 1; e.lwe = 1; e.pc = 9'(rel); end
            3'd2: begin e.tk = 1; e.pc = rd[8:0]; end
            3'd3: begin e.tk = 1; e.lwe = 1; e.pc = rd[8:0]; end
            default: ;
        endcase
        return e;
    endfunction

    // Called #1 after an edge with the DUT idle.
    task automatic do_branch(input logic [2:0] op, input logic [2:0] cond,
                             input logic [7:0] imm, input logic [15:0] rd,
                             input bit ld_acc, input logic [2:0] fl_acc,
                             input bit ld_eval, input logic [2:0] fl_eval,
                             input bit inc_acc, input bit inc_eval,
                             input bit hold);
        exp_t e;
        check("ready_idle", {31'd0, bif.br_ready}, 32'd1);
        bif.br_valid = 1'b1;
        bif.br_op = op;
        bif.br_cond = cond;
        bif.br_imm = imm;
        bif.rd_val = rd;
        pc_inc = inc_acc;
        if (ld_acc) begin
            load_s = 1'b1;
            flags_in = fl_acc;
            ms = fl_acc;
        end
        e = model(op, cond, imm, rd, ms, mpc);
        e.at = cyc + 2;
        sbq.push_back(e);
        @(posedge clk); #1;
        if (!hold) bif.br_valid = 1'b0;
        load_s = 1'b0;
        pc_inc = inc_eval;
        check("ready_busy", {31'd0, bif.br_ready}, 32'd0);
        if (ld_eval) begin
            load_s = 1'b1;
            flags_in = fl_eval;
        end
        @(posedge clk); #1;
        load_s = 1'b0;
        pc_inc = 1'b0;
        if (ld_eval) ms = fl_eval;
        mpc = e.pc;
        if (e.tk) mtk++;
        else mnt++;
        @(posedge clk); #1;
        bif.br_valid = 1'b0;
    endtask

    task automatic br(input logic [2:0] op, input logic [2:0] cond,
                      input logic [7:0] imm, input logic [15:0] rd);
        do_branch(op, cond, imm, rd, 0, 3'd0, 0, 3'd0, 0, 0, 0);
    endtask

    task automatic idle_cycles(input int n, input bit inc);
        pc_inc = inc;
        repeat (n) begin
            @(posedge clk); #1;
            if (inc) mpc = mpc + 9'd1;
        end
        pc_inc = 1'b0;
    endtask

    task automatic load_flags(input logic [2:0] f);
        load_s = 1'b1;
        flags_in = f;
        @(posedge clk); #1;
        load_s = 1'b0;
        ms = f;
    endtask

    initial begin
        reset = 1'b1;
        flags_in = 3'd0;
        load_s = 1'b0;
        pc_inc = 1'b0;
        bif.br_valid = 1'b0;
        bif.br_op = 3'd0;
        bif.br_cond = 3'd0;
        bif.br_imm = 8'd0;
        bif.rd_val = 16'd0;
        mpc = 9'd0;
        ms = 3'd0;
        mtk = 0;
        mnt = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_pc", {23'd0, pc_out}, 32'd0);
        check("rst_s", {29'd0, s_out}, 32'd0);
        check("rst_res_valid", {31'd0, bif.res_valid}, 32'd0);
        check("rst_taken", {31'd0, bif.taken}, 32'd0);
        check("rst_link_we", {31'd0, bif.link_we}, 32'd0);
        check("rst_link_out", {16'd0, bif.link_out}, 32'd0);
        check("rst_ready", {31'd0, bif.br_ready}, 32'd1);

        idle_cycles(3, 1);
        check("inc3_pc", {23'd0, pc_out}, 32'd3);
        check("inc3_s", {29'd0, s_out}, 32'd0);

        br(OP_BX, 3'd0, 8'd0, 16'h01FF);
        idle_cycles(1, 1);
        check("inc_wrap_pc", {23'd0, pc_out}, 32'd0);

        load_flags(3'b001);
        br(OP_BX, 3'd0, 8'd0, 16'd10);
        br(OP_COND, CC_EQ, 8'h05, 16'd0);
        check("eq_pc", {23'd0, pc_out}, 32'd15);
        br(OP_BX, 3'd0, 8'd0, 16'd10);
        br(OP_COND, CC_NE, 8'h05, 16'd0);
        check("ne_pc", {23'd0, pc_out}, 32'd10);

        load_flags(3'b010);
        br(OP_BX, 3'd0, 8'd0, 16'd2);
        br(OP_COND, CC_LT, 8'hFC, 16'd0);
        check("lt_wrap_pc", {23'd0, pc_out}, 32'h1FE);

        br(OP_BX, 3'd0, 8'd0, 16'd20);
        br(OP_BLX, 3'd0, 8'd0, 16'h0040);
        check("blx_pc", {23'd0, pc_out}, 32'd64);
        br(OP_BX, 3'd0, 8'd0, 16'd20);

        load_flags(3'b000);
        do_branch(OP_COND, CC_EQ, 8'h03, 16'd0, 1, 3'b001, 1, 3'b000, 0, 1, 0);
        check("late_load_s", {29'd0, s_out}, 32'd0);
        do_branch(OP_COND, CC_NE, 8'h10, 16'd0, 0, 3'd0, 0, 3'd0, 1, 0, 0);
        br(3'b110, CC_AL, 8'h22, 16'h0033);

        bif.br_valid = 1'b1;
        bif.br_op = OP_BX;
        bif.rd_val = 16'h0077;
        @(posedge clk); #1;
        bif.br_valid = 1'b0;
        reset = 1'b1;
        load_s = 1'b1;
        flags_in = 3'b111;
        @(posedge clk); #1;
        reset = 1'b0;
        load_s = 1'b0;
        mpc = 9'd0;
        ms = 3'd0;
        mtk = 0;
        mnt = 0;
        check("abort_pc", {23'd0, pc_out}, 32'd0);
        check("abort_s", {29'd0, s_out}, 32'd0);
        check("abort_res_valid", {31'd0, bif.res_valid}, 32'd0);
        check("abort_ready", {31'd0, bif.br_ready}, 32'd1);
        idle_cycles(3, 0);

        br(OP_COND, CC_AL, 8'h01, 16'd0);
        br(OP_COND, CC_AL, 8'h02, 16'd0);
        br(OP_COND, 3'b111, 8'h02, 16'd0);
`ifdef BRANCH_STATS_EN
        check("taken_cnt", {16'd0, taken_cnt}, 32'd2);
        check("nottaken_cnt", {16'd0, nottaken_cnt}, 32'd1);
`endif

        for (int i = 0; i < 80; i++) begin
            idle_cycles(int'($urandom_range(0, 2)), 1'($urandom));
            if ($urandom_range(0, 3) == 0) load_flags(3'($urandom));
            do_branch(3'($urandom), 3'($urandom), 8'($urandom),
                      16'($urandom), 1'($urandom), 3'($urandom),
                      1'($urandom), 3'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom));
            check("rand_pc", {23'd0, pc_out}, {23'd0, mpc});
            check("rand_s", {29'd0, s_out}, {29'd0, ms});
        end

        idle_cycles(2, 0);
        check("sb_drained", sbq.size(), 32'd0);
`ifdef BRANCH_STATS_EN
        check("taken_cnt_end", {16'd0, taken_cnt}, mtk);
        check("nottaken_cnt_end", {16'd0, nottaken_cnt}, mnt);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
